// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO registers for the MIPS execute stage.
// MULT/MULTU use shift-add, DIV/DIVU use restoring division; both take 32 iterations.
module muldiv_unit (
  input  logic        clk,
  input  logic        rstn,
  input  logic        Start,
  input  logic [2:0]  MdCtrl,
  input  logic [31:0] DataIn1,
  input  logic [31:0] DataIn2,
  output logic        Busy,
  output logic        Done,
  output logic        DivZero,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_RUN    = 1'b1;
  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]  r_state;
  logic [5:0]  r_cnt;
  logic [2:0]  r_op;
  logic        r_sign1;
  logic        r_sign2;
  logic [63:0] r_acc;
  logic [31:0] r_opb;
  logic        r_busy;
  logic        r_done;
  logic        r_divzero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_abs1;
  logic [31:0] w_abs2;
  logic        w_is_mul;
  logic [32:0] w_sum;
  logic        w_ge;
  logic [31:0] w_trial;
  logic [63:0] w_acc_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo;
  logic [31:0] w_rem;
  logic        w_div_zero;

  function automatic logic [31:0] abs32(input logic [31:0] v, input logic en);
    abs32 = (en && v[31]) ? (32'd0 - v) : v;
  endfunction

  // Operand conditioning and one shift-add / restoring-divide step.
  always_comb begin
    w_signed = (MdCtrl == OP_MULT) || (MdCtrl == OP_DIV);
    w_abs1   = abs32(DataIn1, w_signed);
    w_abs2   = abs32(DataIn2, w_signed);
    w_is_mul = (r_op == OP_MULT) || (r_op == OP_MULTU);
    // Accumulator holds {partial/remainder, multiplier/quotient}.
    w_sum    = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opb} : 33'd0);
    w_ge     = (r_acc[63:31] >= {1'b0, r_opb});
    w_trial  = r_acc[62:31] - r_opb;
    if (w_is_mul) begin
      w_acc_next = {w_sum, r_acc[31:1]};
    end else if (w_ge) begin
      w_acc_next = {w_trial, r_acc[30:0], 1'b1};
    end else begin
      w_acc_next = {r_acc[62:0], 1'b0};
    end
    w_prod     = ((r_op == OP_MULT) && (r_sign1 ^ r_sign2)) ? (64'd0 - w_acc_next) : w_acc_next;
    w_quo      = ((r_op == OP_DIV) && (r_sign1 ^ r_sign2)) ? (32'd0 - w_acc_next[31:0]) : w_acc_next[31:0];
    w_rem      = ((r_op == OP_DIV) && r_sign1) ? (32'd0 - w_acc_next[63:32]) : w_acc_next[63:32];
    w_div_zero = (r_opb == 32'd0);
  end

  // Control FSM, shadow datapath and HI/LO commit.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= S_IDLE;
      r_cnt     <= 6'd0;
      r_op      <= OP_NOP;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_acc     <= 64'd0;
      r_opb     <= 32'd0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
    end else begin
      r_done    <= 1'b0;
      r_divzero <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Start) begin
            case (MdCtrl)
              OP_MTHI: r_hi <= DataIn1;
              OP_MTLO: r_lo <= DataIn1;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_op    <= MdCtrl;
                r_sign1 <= w_signed & DataIn1[31];
                r_sign2 <= w_signed & DataIn2[31];
                r_acc   <= {32'd0, w_abs1};
                r_opb   <= w_abs2;
                r_cnt   <= 6'd32;
                r_busy  <= 1'b1;
                r_state <= S_RUN;
              end
              OP_NOP:  r_state <= S_IDLE;
              default: r_state <= S_IDLE;
            endcase
          end
        end
        S_RUN: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt - 6'd1;
          if (r_cnt == 6'd1) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            if (w_is_mul) begin
              r_hi <= w_prod[63:32];
              r_lo <= w_prod[31:0];
            end else if (w_div_zero) begin
              r_divzero <= 1'b1;
            end else begin
              r_hi <= w_rem;
              r_lo <= w_quo;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Busy    = r_busy;
  assign Done    = r_done;
  assign DivZero = r_divzero;
  assign Hi      = r_hi;
  assign Lo      = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected {DivZero,Hi,Lo}, a monitor checks on Done.
module tb_muldiv_unit;

  logic        clk;
  logic        rstn;
  logic        Start;
  logic [2:0]  MdCtrl;
  logic [31:0] DataIn1;
  logic [31:0] DataIn2;
  logic        Busy;
  logic        Done;
  logic        DivZero;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int tests = 0;
  int fails = 0;
  int done_events = 0;
  logic prev_done = 1'b0;
  logic [64:0] sb[$];

  muldiv_unit dut (
    .clk(clk), .rstn(rstn), .Start(Start), .MdCtrl(MdCtrl),
    .DataIn1(DataIn1), .DataIn2(DataIn2), .Busy(Busy), .Done(Done),
    .DivZero(DivZero), .Hi(Hi), .Lo(Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard whenever the unit reports completion.
  always @(negedge clk) begin
    logic [64:0] e;
    if (rstn) begin
      if (Done) begin
        done_events++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_done: got Done=1 expected no pending op");
        end else begin
          e = sb.pop_front();
          chk("result_hi", Hi, e[63:32]);
          chk("result_lo", Lo, e[31:0]);
          chk("divzero", {31'd0, DivZero}, {31'd0, e[64]});
        end
        chk("busy_at_done", {31'd0, Busy}, 32'd0);
        if (prev_done) chk("done_single_pulse", 32'd1, 32'd0);
      end else if (DivZero) begin
        chk("divzero_without_done", {31'd0, DivZero}, 32'd0);
      end
      prev_done = Done;
    end else begin
      prev_done = 1'b0;
    end
  end

  // Drive one request; assumes the caller is at a falling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; MdCtrl = op; DataIn1 = a; DataIn2 = b;
    @(negedge clk);
    Start = 1'b0; MdCtrl = 3'd0; DataIn1 = 32'h0; DataIn2 = 32'h0;
  endtask

  // Wait (bounded) for Done, checking latency and that Hi/Lo hold while Busy.
  task automatic wait_done(input int n, input logic [31:0] hold_hi, input logic [31:0] hold_lo);
    int found = -1;
    logic held_bad = 1'b0;
    for (int i = 1; i <= n + 8; i++) begin
      @(negedge clk);
      if (Done) begin
        found = i;
        break;
      end
      if (Busy && (Hi !== hold_hi || Lo !== hold_lo)) held_bad = 1'b1;
    end
    chk("done_latency", found, n);
    chk("hilo_hold_while_busy", {31'd0, held_bad}, 32'd0);
  endtask

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  initial begin
    rstn = 1'b0; Start = 1'b0; MdCtrl = 3'd0; DataIn1 = 32'h0; DataIn2 = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    chk("rst_divzero", {31'd0, DivZero}, 32'd0);
    chk("rst_hi", Hi, 32'h0);
    chk("rst_lo", Lo, 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    // MTHI then MTLO: no Busy, no Done
    issue(3'd5, 32'h12345678, 32'h0);
    chk("mthi_hi", Hi, 32'h12345678);
    chk("mthi_busy", {31'd0, Busy}, 32'd0);
    issue(3'd6, 32'hCAFEBABE, 32'h0);
    chk("mtlo_lo", Lo, 32'hCAFEBABE);
    chk("mtlo_hi", Hi, 32'h12345678);
    chk("mtlo_busy", {31'd0, Busy}, 32'd0);
    @(negedge clk);
    chk("mt_no_done", done_events, 0);
    m_hi = 32'h12345678; m_lo = 32'hCAFEBABE;

    // MULT -1 * 5 and MULTU 0xFFFFFFFF * 5
    sb.push_back({1'b0, 32'hFFFFFFFF, 32'hFFFFFFFB});
    issue(3'd1, 32'hFFFFFFFF, 32'd5);
    wait_done(32, m_hi, m_lo);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFB;
    @(negedge clk);
    sb.push_back({1'b0, 32'h00000004, 32'hFFFFFFFB});
    issue(3'd2, 32'hFFFFFFFF, 32'd5);
    wait_done(32, m_hi, m_lo);
    m_hi = 32'h00000004; m_lo = 32'hFFFFFFFB;

    // DIV -7 / 2 and DIVU 7 / 2
    @(negedge clk);
    sb.push_back({1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD});
    issue(3'd3, 32'hFFFFFFF9, 32'd2);
    wait_done(32, m_hi, m_lo);
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFFFFFD;
    @(negedge clk);
    sb.push_back({1'b0, 32'h00000001, 32'h00000003});
    issue(3'd4, 32'd7, 32'd2);
    wait_done(32, m_hi, m_lo);

    // Divide by zero leaves Hi/Lo untouched
    @(negedge clk);
    issue(3'd5, 32'hAAAA0000, 32'h0);
    issue(3'd6, 32'h00005555, 32'h0);
    m_hi = 32'hAAAA0000; m_lo = 32'h00005555;
    sb.push_back({1'b1, 32'hAAAA0000, 32'h00005555});
    issue(3'd4, 32'd9, 32'd0);
    wait_done(32, m_hi, m_lo);

    // MULT -3 * 4 with an MTLO attempted mid-run
    @(negedge clk);
    sb.push_back({1'b0, 32'hFFFFFFFF, 32'hFFFFFFF4});
    issue(3'd1, 32'hFFFFFFFD, 32'd4);
    repeat (4) @(negedge clk);
    issue(3'd6, 32'hDEADBEEF, 32'h0);
    wait_done(27, m_hi, m_lo);
    repeat (2) @(negedge clk);
    chk("mtlo_not_queued", Lo, 32'hFFFFFFF4);
    chk("busy_after_ignored_mt", {31'd0, Busy}, 32'd0);

    // Reset in the middle of a DIV
    sb.push_back({1'b0, 32'h0, 32'h0});
    issue(3'd3, 32'd100, 32'd7);
    void'(sb.pop_back());
    repeat (10) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("abort_busy", {31'd0, Busy}, 32'd0);
    chk("abort_hi", Hi, 32'h0);
    chk("abort_lo", Lo, 32'h0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_no_done", {31'd0, Done}, 32'd0);
    chk("abort_hi_stays", Hi, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;

    // Overflow DIV, then back-to-back DIVU issued on the Done cycle
    @(negedge clk);
    sb.push_back({1'b0, 32'h00000000, 32'h80000000});
    issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
    wait_done(32, m_hi, m_lo);
    m_hi = 32'h0; m_lo = 32'h80000000;
    sb.push_back({1'b0, 32'h00000002, 32'h0000000E});
    issue(3'd4, 32'd100, 32'd7);
    chk("b2b_accepted_busy", {31'd0, Busy}, 32'd1);
    wait_done(32, m_hi, m_lo);

    @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
